s1_feed_ctrl: RTL

//  Upstream feeder for the s1 registered 4:1 mux cell. Collects four N-bit words over a valid/ready

---
 rtl/s1_feed_ctrl_pkg.sv | 19 +
 rtl/s1_feed_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/s1_feed_ctrl_pkg.sv
// Shared definitions for the s1 feeder: FSM states, batch size and drain-order select helper.
package s1_feed_ctrl_pkg;

  localparam int NUM_WORDS = 4;
  localparam int SEL_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  // Maps the drain step counter onto the holding-register index for the chosen order.
  function automatic logic [SEL_W-1:0] drain_sel(input logic rev_q, input logic [SEL_W-1:0] cnt);
    return rev_q ? (SEL_W'(NUM_WORDS - 1) - cnt) : cnt;
  endfunction

endpackage

// File: rtl/s1_feed_ctrl.sv
// Loads four words into holding registers, then steps the s1 mux selects so each word is emitted once.
module s1_feed_ctrl
  import s1_feed_ctrl_pkg::*;
#(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         rev,
  input  logic         flush,
  output logic [N-1:0] D0,
  output logic [N-1:0] D1,
  output logic [N-1:0] D2,
  output logic [N-1:0] D3,
  output logic         A1,
  output logic         B1,
  output logic         A0,
  output logic         s1_clr,
  output logic         out_valid,
  output logic [1:0]   out_idx,
  output logic         busy
);

  state_t           r_state;
  state_t           w_state_next;
  logic [SEL_W-1:0] r_cnt;
  logic [SEL_W-1:0] w_cnt_next;
  logic [N-1:0]     r_d [NUM_WORDS];
  logic             r_rev;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_out_idx;

  logic             w_accept;
  logic             w_store;
  logic             w_clear_d;
  logic             w_latch_rev;
  logic [SEL_W-1:0] w_wr_idx;
  logic [SEL_W-1:0] w_sel;

  assign in_ready = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign w_accept = in_valid && in_ready;
  assign w_sel    = (r_state == ST_DRAIN) ? drain_sel(r_rev, r_cnt) : '0;
  assign w_wr_idx = (r_state == ST_IDLE) ? '0 : r_cnt;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_store      = 1'b0;
    w_clear_d    = 1'b0;
    w_latch_rev  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_store      = 1'b1;
          w_cnt_next   = 2'd1;
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // A word offered alongside flush is dropped together with the partial batch.
        if (flush) begin
          w_clear_d    = 1'b1;
          w_cnt_next   = '0;
          w_state_next = ST_IDLE;
        end else if (w_accept) begin
          w_store = 1'b1;
          if (r_cnt == SEL_W'(NUM_WORDS - 1)) begin
            w_latch_rev  = 1'b1;
            w_cnt_next   = '0;
            w_state_next = ST_DRAIN;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (flush || r_cnt == SEL_W'(NUM_WORDS - 1)) begin
          w_cnt_next   = '0;
          w_state_next = ST_CLEAR;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rev       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      for (int i = 0; i < NUM_WORDS; i++) r_d[i] <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      // Registered so valid/index line up with the s1 cell's one-cycle output register.
      r_out_valid <= (r_state == ST_DRAIN) && !flush;
      r_out_idx   <= w_sel;
      if (w_latch_rev) r_rev <= rev;
      if (w_clear_d) begin
        for (int i = 0; i < NUM_WORDS; i++) r_d[i] <= '0;
      end else if (w_store) begin
        r_d[w_wr_idx] <= in_data;
      end
    end
  end

  assign D0        = r_d[0];
  assign D1        = r_d[1];
  assign D2        = r_d[2];
  assign D3        = r_d[3];
  assign A1        = w_sel[1];
  assign A0        = w_sel[0];
  assign B1        = 1'b0;
  assign s1_clr    = (r_state != ST_DRAIN);
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign busy      = (r_state != ST_IDLE);

endmodule
